// File: rtl/mips_dmem_mmio_if.sv
// Data-port bus between the single-cycle MIPS core and its data-side responder.
// The core drives the store strobe, byte address and store data; the responder
// returns load data combinationally in the same cycle.
interface mips_dmem_mmio_if;
   logic        memwrite;
   logic [31:0] addr;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (
      output memwrite,
      output addr,
      output writedata,
      input  readdata
   );

   modport slave (
      input  memwrite,
      input  addr,
      input  writedata,
      output readdata
   );
endinterface

// File: rtl/mips_dmem_mmio.sv
// Data-side responder for the single-cycle MIPS core: word-addressed data RAM
// plus one memory-mapped page holding the LED register, a compare/auto-reload
// timer with a level interrupt, and a free-running cycle counter.
module mips_dmem_mmio #(
   parameter int          DEPTH_WORDS = 64,
   parameter logic [15:0] MMIO_PAGE   = 16'hFFFF
) (
   input  logic                 clk,
   input  logic                 reset,
   mips_dmem_mmio_if.slave      bus,
   output logic [7:0]           leds,
   output logic                 timer_irq
);

   localparam int AW = $clog2(DEPTH_WORDS);

   // Word offsets inside the peripheral page (byte offset >> 2)
   localparam logic [13:0] OFF_LEDS   = 14'd0;
   localparam logic [13:0] OFF_TCOUNT = 14'd1;
   localparam logic [13:0] OFF_TCMP   = 14'd2;
   localparam logic [13:0] OFF_TCTRL  = 14'd3;
   localparam logic [13:0] OFF_CYCLES = 14'd4;

   logic [31:0]   mem [DEPTH_WORDS];

   logic          mmio_sel;
   logic [13:0]   word_off;
   logic [AW-1:0] ram_idx;
   logic          wr_ram;
   logic          wr_leds;
   logic          wr_tcount;
   logic          wr_tcmp;
   logic          wr_tctrl;
   logic          unused_addr_bits;

   logic [7:0]    leds_q;
   logic [31:0]   tcount_q;
   logic [31:0]   tcmp_q;
   logic          en_q;
   logic          irqen_q;
   logic          match_q;
   logic [31:0]   cycles_q;

   logic          timer_hit;
   logic [31:0]   tcount_next;
   logic          match_next;

   // Only word accesses exist, so the byte lane bits never take part in decode
   assign unused_addr_bits = ^bus.addr[1:0];

   assign mmio_sel = (bus.addr[31:16] == MMIO_PAGE);
   assign word_off = bus.addr[15:2];
   assign ram_idx  = bus.addr[AW+1:2];

   // Address decode for the store strobe; writes to unmapped offsets fall through
   always_comb begin
      wr_ram    = 1'b0;
      wr_leds   = 1'b0;
      wr_tcount = 1'b0;
      wr_tcmp   = 1'b0;
      wr_tctrl  = 1'b0;
      if (bus.memwrite) begin
         if (!mmio_sel) begin
            wr_ram = 1'b1;
         end else begin
            case (word_off)
               OFF_LEDS:   wr_leds   = 1'b1;
               OFF_TCOUNT: wr_tcount = 1'b1;
               OFF_TCMP:   wr_tcmp   = 1'b1;
               OFF_TCTRL:  wr_tctrl  = 1'b1;
               default:    ;
            endcase
         end
      end
   end

   // Timer step: the match uses the pre-write count and the old enable, a
   // software count write wins over increment/reload, and a hardware match
   // wins over a write-1-to-clear landing on the same edge
   always_comb begin
      timer_hit   = en_q && (tcount_q == tcmp_q);
      tcount_next = tcount_q;
      match_next  = match_q;
      if (en_q) begin
         tcount_next = timer_hit ? 32'd0 : tcount_q + 32'd1;
      end
      if (wr_tcount) begin
         tcount_next = bus.writedata;
      end
      if (wr_tctrl && bus.writedata[2]) begin
         match_next = 1'b0;
      end
      if (timer_hit) begin
         match_next = 1'b1;
      end
   end

   // Data RAM has no reset; contents persist across core resets
   always_ff @(posedge clk) begin
      if (wr_ram) begin
         mem[ram_idx] <= bus.writedata;
      end
   end

   // Peripheral registers, cleared immediately whenever reset is held low
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         leds_q   <= 8'd0;
         tcount_q <= 32'd0;
         tcmp_q   <= 32'hFFFF_FFFF;
         en_q     <= 1'b0;
         irqen_q  <= 1'b0;
         match_q  <= 1'b0;
         cycles_q <= 32'd0;
      end else begin
         tcount_q <= tcount_next;
         match_q  <= match_next;
         cycles_q <= cycles_q + 32'd1;
         if (wr_leds) begin
            leds_q <= bus.writedata[7:0];
         end
         if (wr_tcmp) begin
            tcmp_q <= bus.writedata;
         end
         if (wr_tctrl) begin
            en_q    <= bus.writedata[0];
            irqen_q <= bus.writedata[1];
         end
      end
   end

   // Zero-latency load mux; a same-cycle store is not yet visible here
   always_comb begin
      bus.readdata = 32'd0;
      if (!mmio_sel) begin
         bus.readdata = mem[ram_idx];
      end else begin
         case (word_off)
            OFF_LEDS:   bus.readdata = {24'd0, leds_q};
            OFF_TCOUNT: bus.readdata = tcount_q;
            OFF_TCMP:   bus.readdata = tcmp_q;
            OFF_TCTRL:  bus.readdata = {29'd0, match_q, irqen_q, en_q};
            OFF_CYCLES: bus.readdata = cycles_q;
            default:    bus.readdata = 32'd0;
         endcase
      end
   end

   assign leds      = leds_q;
   assign timer_irq = match_q & irqen_q;

endmodule

// File: tb/tb_mips_dmem_mmio.sv
// Directed scoreboard bench for the MIPS data-side responder: RAM aliasing and
// read-before-write, LED register, unmapped offsets, timer sequencing and
// same-edge priorities, and asynchronous reset mid-count.
module tb_mips_dmem_mmio;

   localparam logic [31:0] A_LEDS   = 32'hFFFF_0000;
   localparam logic [31:0] A_TCOUNT = 32'hFFFF_0004;
   localparam logic [31:0] A_TCMP   = 32'hFFFF_0008;
   localparam logic [31:0] A_TCTRL  = 32'hFFFF_000C;
   localparam logic [31:0] A_CYCLES = 32'hFFFF_0010;
   localparam logic [31:0] A_HOLE   = 32'hFFFF_0014;

   typedef struct {
      string       tag;
      logic [31:0] value;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] leds;
   logic       timer_irq;
   exp_t       sb[$];
   int         checks = 0;
   int         errors = 0;

   mips_dmem_mmio_if bus ();

   mips_dmem_mmio #(
      .DEPTH_WORDS (64),
      .MMIO_PAGE   (16'hFFFF)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .leds      (leds),
      .timer_irq (timer_irq)
   );

   // 10-unit clock; stimulus changes on the falling edge, checks land 1..4 units later
   always #5 clk = ~clk;

   // Move to the next falling edge and drive a new bus request
   task automatic applyStimulus(input logic we, input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      bus.memwrite  = we;
      bus.addr      = a;
      bus.writedata = d;
   endtask

   // Queue an expected result for the next observed output
   task automatic expectVal(input string tag, input logic [31:0] v);
      sb.push_back('{tag, v});
   endtask

   // Pop the oldest expectation and compare it against what the DUT shows
   task automatic checkOutput(input logic [31:0] actual);
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $error("[TB] FAIL scoreboard_empty: got %h with nothing expected", actual);
      end else begin
         e = sb.pop_front();
         assert (actual === e.value) else begin
            errors++;
            $error("[TB] FAIL %s: got %h expected %h", e.tag, actual, e.value);
         end
      end
   endtask

   // Non-writing load in the current cycle, checked one unit later
   task automatic readAt(input string tag, input logic [31:0] a, input logic [31:0] v);
      bus.memwrite  = 1'b0;
      bus.addr      = a;
      bus.writedata = 32'd0;
      expectVal(tag, v);
      #1;
      checkOutput(bus.readdata);
   endtask

   // Directed sequence; timer counts in comments are the value seen at each falling edge
   initial begin
      bus.memwrite  = 1'b0;
      bus.addr      = 32'd0;
      bus.writedata = 32'd0;
      reset         = 1'b1;
      #2 reset = 1'b0;
      #1;
      expectVal("rst_leds", 32'd0);
      checkOutput({24'd0, leds});
      expectVal("rst_irq", 32'd0);
      checkOutput({31'd0, timer_irq});

      @(negedge clk);
      reset = 1'b1;
      readAt("rst_tcmp", A_TCMP, 32'hFFFF_FFFF);
      readAt("rst_tctrl", A_TCTRL, 32'd0);
      readAt("rst_cycles", A_CYCLES, 32'd0);
      readAt("rst_tcount", A_TCOUNT, 32'd0);
      applyStimulus(1'b0, A_CYCLES, 32'd0);
      readAt("cycles_one", A_CYCLES, 32'd1);

      // RAM: same-cycle read returns the old word, aliased address sees the new one
      applyStimulus(1'b1, 32'h0000_0010, 32'h1111_1111);
      applyStimulus(1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
      expectVal("ram_read_during_write", 32'h1111_1111);
      #1;
      checkOutput(bus.readdata);
      applyStimulus(1'b0, 32'h0000_0010, 32'd0);
      readAt("ram_read", 32'h0000_0010, 32'hDEAD_BEEF);
      readAt("ram_alias", 32'h0000_0110, 32'hDEAD_BEEF);
      readAt("ram_byte_lane", 32'h0000_0013, 32'hDEAD_BEEF);

      // LED register keeps only the low byte; unmapped offset stays inert
      applyStimulus(1'b1, A_LEDS, 32'h0000_01A5);
      applyStimulus(1'b1, A_HOLE, 32'h1234_5678);
      expectVal("leds_out", 32'h0000_00A5);
      checkOutput({24'd0, leds});
      applyStimulus(1'b0, A_LEDS, 32'd0);
      readAt("leds_read", A_LEDS, 32'h0000_00A5);
      readAt("hole_read", A_HOLE, 32'd0);
      readAt("hole_tcmp", A_TCMP, 32'hFFFF_FFFF);
      readAt("hole_tcount", A_TCOUNT, 32'd0);

      // Timer compare 3 with auto-reload; enable takes effect after its own edge
      applyStimulus(1'b1, A_TCMP, 32'd3);
      applyStimulus(1'b1, A_TCTRL, 32'd3);
      applyStimulus(1'b0, A_TCOUNT, 32'd0);
      readAt("tc_seq0", A_TCOUNT, 32'd0);
      applyStimulus(1'b0, A_TCOUNT, 32'd0);
      readAt("tc_seq1", A_TCOUNT, 32'd1);
      applyStimulus(1'b0, A_TCOUNT, 32'd0);
      readAt("tc_seq2", A_TCOUNT, 32'd2);
      applyStimulus(1'b0, A_TCOUNT, 32'd0);
      readAt("tc_seq3", A_TCOUNT, 32'd3);
      expectVal("irq_before_match", 32'd0);
      checkOutput({31'd0, timer_irq});
      applyStimulus(1'b0, A_TCOUNT, 32'd0);
      readAt("tc_reload", A_TCOUNT, 32'd0);
      readAt("tctrl_match", A_TCTRL, 32'd7);
      expectVal("irq_on_match", 32'd1);
      checkOutput({31'd0, timer_irq});

      // Write-1-to-clear on a non-matching edge (count 1 -> 2)
      applyStimulus(1'b1, A_TCTRL, 32'd7);
      applyStimulus(1'b0, A_TCTRL, 32'd0);
      readAt("w1c_tctrl", A_TCTRL, 32'd3);
      readAt("w1c_tcount", A_TCOUNT, 32'd2);
      expectVal("w1c_irq", 32'd0);
      checkOutput({31'd0, timer_irq});

      // Write-1-to-clear on the match edge (count 3): hardware set wins
      applyStimulus(1'b1, A_TCTRL, 32'd7);
      applyStimulus(1'b0, A_TCTRL, 32'd0);
      readAt("w1c_vs_match_tctrl", A_TCTRL, 32'd7);
      readAt("w1c_vs_match_tcount", A_TCOUNT, 32'd0);
      expectVal("w1c_vs_match_irq", 32'd1);
      checkOutput({31'd0, timer_irq});

      // Clear at count 1, then overwrite TCOUNT on the count-3 match edge
      applyStimulus(1'b1, A_TCTRL, 32'd7);
      applyStimulus(1'b0, A_TCTRL, 32'd0);
      readAt("clear_tctrl", A_TCTRL, 32'd3);
      readAt("clear_tcount", A_TCOUNT, 32'd2);
      applyStimulus(1'b1, A_TCOUNT, 32'd100);
      applyStimulus(1'b0, A_TCOUNT, 32'd0);
      readAt("sw_over_reload_tcount", A_TCOUNT, 32'd100);
      readAt("sw_over_reload_tctrl", A_TCTRL, 32'd7);

      // Writing 4 clears MATCH and disables the timer (count 101 -> 102)
      applyStimulus(1'b1, A_TCTRL, 32'd4);
      applyStimulus(1'b0, A_TCTRL, 32'd0);
      readAt("wr4_tctrl", A_TCTRL, 32'd0);
      readAt("wr4_tcount", A_TCOUNT, 32'd102);
      expectVal("wr4_irq", 32'd0);
      checkOutput({31'd0, timer_irq});
      applyStimulus(1'b0, A_TCOUNT, 32'd0);
      readAt("disabled_hold", A_TCOUNT, 32'd102);

      // Re-enable from count 1: the enabling edge itself must not step the count
      applyStimulus(1'b1, A_TCOUNT, 32'd1);
      applyStimulus(1'b1, A_TCTRL, 32'd3);
      applyStimulus(1'b1, A_LEDS, 32'h0000_00FF);
      applyStimulus(1'b0, A_TCOUNT, 32'd0);
      readAt("old_en_step", A_TCOUNT, 32'd2);
      applyStimulus(1'b0, A_TCOUNT, 32'd0);
      applyStimulus(1'b0, A_TCOUNT, 32'd0);
      applyStimulus(1'b0, A_TCOUNT, 32'd0);
      applyStimulus(1'b0, A_TCOUNT, 32'd0);
      readAt("pre_reset_tcount", A_TCOUNT, 32'd2);
      expectVal("pre_reset_irq", 32'd1);
      checkOutput({31'd0, timer_irq});
      expectVal("pre_reset_leds", 32'h0000_00FF);
      checkOutput({24'd0, leds});

      // Asynchronous reset between edges clears outputs without a clock
      #1 reset = 1'b0;
      #1;
      expectVal("async_rst_leds", 32'd0);
      checkOutput({24'd0, leds});
      expectVal("async_rst_irq", 32'd0);
      checkOutput({31'd0, timer_irq});
      applyStimulus(1'b0, A_TCOUNT, 32'd0);
      applyStimulus(1'b0, A_TCOUNT, 32'd0);
      reset = 1'b1;
      readAt("post_rst_tcount", A_TCOUNT, 32'd0);
      readAt("post_rst_cycles", A_CYCLES, 32'd0);
      readAt("post_rst_tctrl", A_TCTRL, 32'd0);
      readAt("post_rst_tcmp", A_TCMP, 32'hFFFF_FFFF);
      applyStimulus(1'b0, A_CYCLES, 32'd0);
      readAt("post_rst_cycles1", A_CYCLES, 32'd1);
      readAt("post_rst_ram_kept", 32'h0000_0010, 32'hDEAD_BEEF);

      if (sb.size() != 0) begin
         errors++;
         $display("[TB] FAIL scoreboard_leftover: got %0d entries expected 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
